// File: rtl/csd2bin_serial.sv
// csd2bin_serial: serial canonic-signed-digit to two's-complement converter.
// One CSD digit is consumed per clock, least significant digit first, and the
// result plus error/non-canonical flags are presented with a valid/ready
// handshake once every digit of the word has been folded in.
module csd2bin_serial #(
  parameter int W     = 8,
  parameter int LOG2W = 3
) (
  input  logic           clk,
  input  logic           srst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] in_csd,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_bin,
  output logic           out_err,
  output logic           out_noncanon
);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic [2*W-1:0]   r_shift;
  logic [W-1:0]     r_acc;
  logic             r_err;
  logic             r_noncanon;
  logic [LOG2W-1:0] r_cnt;
  logic [1:0]       r_prevDigit;
  logic [W-1:0]     r_outBin;
  logic             r_outErr;
  logic             r_outNoncanon;

  logic [1:0]   w_digit;
  logic         w_digitNonzero;
  logic         w_prevNonzero;
  logic [W-1:0] w_weight;
  logic         w_lastDigit;
  logic [W-1:0] w_accNext;
  logic         w_errNext;
  logic         w_noncanonNext;

  // The digit under conversion always sits in the bottom two bits of the shift register.
  assign w_digit        = r_shift[1:0];
  assign w_digitNonzero = (w_digit == 2'b01) || (w_digit == 2'b11);
  assign w_prevNonzero  = (r_prevDigit == 2'b01) || (r_prevDigit == 2'b11);
  assign w_weight       = W'(1) << r_cnt;
  assign w_lastDigit    = (r_cnt == LOG2W'(W - 1));

  assign out_bin      = r_outBin;
  assign out_err      = r_outErr;
  assign out_noncanon = r_outNoncanon;

  // Fold the current digit into the accumulator and update the sticky flags.
  // The illegal code 10 adds nothing and counts as a zero digit for adjacency.
  always_comb begin
    w_accNext      = r_acc;
    w_errNext      = r_err;
    w_noncanonNext = r_noncanon;
    case (w_digit)
      2'b01:   w_accNext = r_acc + w_weight;
      2'b11:   w_accNext = r_acc - w_weight;
      2'b10:   w_errNext = 1'b1;
      default: w_accNext = r_acc;
    endcase
    if (w_digitNonzero && w_prevNonzero) begin
      w_noncanonNext = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!srst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic and handshake outputs, decoded purely from the state.
  always_comb begin
    w_nextState = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_nextState = CONV;
        end
      end
      CONV: begin
        if (w_lastDigit) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Datapath: capture a word in IDLE, convert one digit per cycle in CONV, and
  // publish the final result on the last digit so it already includes that digit.
  always_ff @(posedge clk) begin
    if (!srst_n) begin
      r_shift       <= '0;
      r_acc         <= '0;
      r_err         <= 1'b0;
      r_noncanon    <= 1'b0;
      r_cnt         <= '0;
      r_prevDigit   <= 2'b00;
      r_outBin      <= '0;
      r_outErr      <= 1'b0;
      r_outNoncanon <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_shift     <= in_csd;
            r_acc       <= '0;
            r_err       <= 1'b0;
            r_noncanon  <= 1'b0;
            r_cnt       <= '0;
            r_prevDigit <= 2'b00;
          end
        end
        CONV: begin
          r_shift     <= r_shift >> 2;
          r_acc       <= w_accNext;
          r_err       <= w_errNext;
          r_noncanon  <= w_noncanonNext;
          r_prevDigit <= w_digit;
          if (w_lastDigit) begin
            r_outBin      <= w_accNext;
            r_outErr      <= w_errNext;
            r_outNoncanon <= w_noncanonNext;
          end else begin
            r_cnt <= r_cnt + LOG2W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csd2bin_serial.sv
// Self-checking bench for csd2bin_serial: directed corner words, back-pressure,
// mid-conversion reset and a randomised run of canonical words with a scoreboard.
module tb_csd2bin_serial;

  localparam int W     = 8;
  localparam int LOG2W = 3;

  typedef struct {
    logic [W-1:0] bin;
    logic         err;
    logic         nc;
  } exp_t;

  logic           clk = 1'b0;
  logic           srst_n;
  logic           in_valid;
  logic           in_ready;
  logic [2*W-1:0] in_csd;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_bin;
  logic           out_err;
  logic           out_noncanon;

  logic forcedReady;
  logic randomReady = 1'b1;
  logic randomMode;

  exp_t expQ[$];
  exp_t monExp;
  int   testsRun    = 0;
  int   testsFailed = 0;

  csd2bin_serial #(.W(W), .LOG2W(LOG2W)) dut (
    .clk          (clk),
    .srst_n       (srst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_csd       (in_csd),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_bin      (out_bin),
    .out_err      (out_err),
    .out_noncanon (out_noncanon)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Consumer ready is either fixed by the main sequence or randomised.
  always_comb begin
    out_ready = randomMode ? randomReady : forcedReady;
  end

  // Random back-pressure source, changed just after each rising edge.
  always @(posedge clk) begin
    #1;
    randomReady = 1'($urandom_range(0, 1));
  end

  // Single comparison point for every check in the bench.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Reference converter: non-adjacent form of a W-bit value, truncated to W digits.
  function automatic logic [2*W-1:0] bin2csd(input logic [W-1:0] v);
    logic [2*W-1:0] csd;
    int x;
    csd = '0;
    x   = int'(v);
    for (int i = 0; i < W; i++) begin
      if ((x % 2) != 0) begin
        if ((x % 4) == 1) begin
          csd[2*i +: 2] = 2'b01;
          x = x - 1;
        end else begin
          csd[2*i +: 2] = 2'b11;
          x = x + 1;
        end
      end
      x = x / 2;
    end
    return csd;
  endfunction

  // Scoreboard side: every completed output handshake is compared with the oldest expectation.
  always @(negedge clk) begin
    if (srst_n && out_valid && out_ready) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedOutput", 32'd1, 32'd0);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("outBin", 32'(out_bin), 32'(monExp.bin));
        checkOutput("outErr", 32'(out_err), 32'(monExp.err));
        checkOutput("outNoncanon", 32'(out_noncanon), 32'(monExp.nc));
      end
    end
  end

  // Offer a word, optionally record its expected result, and return once it is accepted.
  // Called and returns just after a rising edge.
  task automatic applyStimulus(input logic [2*W-1:0] csd, input logic [W-1:0] expBin,
                               input logic expErr, input logic expNc, input bit expectOut);
    exp_t e;
    int waited;
    if (expectOut) begin
      e.bin = expBin;
      e.err = expErr;
      e.nc  = expNc;
      expQ.push_back(e);
    end
    in_csd   = csd;
    in_valid = 1'b1;
    waited   = 0;
    while (!in_ready && waited < 100) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (!in_ready) begin
      checkOutput("acceptTimeout", 32'd0, 32'd1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_csd   = (2*W)'($urandom);
    end
  endtask

  // Wait until every expected result has been delivered.
  task automatic waitDrain();
    int n;
    n = 0;
    while (expQ.size() != 0 && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("drainTimeout", 32'(expQ.size()), 32'd0);
  endtask

  // Hard stop in case the sequence ever stalls.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main stimulus sequence.
  initial begin
    int lat;
    int n;
    logic sawValid;
    logic [W-1:0] v;

    srst_n      = 1'b0;
    in_valid    = 1'b0;
    in_csd      = '0;
    forcedReady = 1'b1;
    randomMode  = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstInReady", 32'(in_ready), 32'd1);
    checkOutput("rstOutValid", 32'(out_valid), 32'd0);
    checkOutput("rstOutBin", 32'(out_bin), 32'd0);
    checkOutput("rstOutErr", 32'(out_err), 32'd0);
    checkOutput("rstOutNoncanon", 32'(out_noncanon), 32'd0);
    srst_n = 1'b1;
    @(posedge clk);
    #1;

    // First word with latency measured from the accepting cycle (counted as 1).
    expQ.push_back('{bin: 8'h01, err: 1'b0, nc: 1'b0});
    in_csd   = 16'h0001;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput("latency", 32'(lat), 32'(W + 1));
    waitDrain();

    // Directed words covering mixed signs, illegal code and all-ones patterns.
    applyStimulus(16'h0103, 8'h0F, 1'b0, 1'b0, 1'b1); waitDrain();
    applyStimulus(16'h0003, 8'hFF, 1'b0, 1'b0, 1'b1); waitDrain();
    applyStimulus(16'h0005, 8'h03, 1'b0, 1'b1, 1'b1); waitDrain();
    applyStimulus(16'h0002, 8'h00, 1'b1, 1'b0, 1'b1); waitDrain();
    applyStimulus(16'h5555, 8'hFF, 1'b0, 1'b1, 1'b1); waitDrain();
    applyStimulus(16'hFFFF, 8'h01, 1'b0, 1'b1, 1'b1); waitDrain();
    applyStimulus(16'hC000, 8'h80, 1'b0, 1'b0, 1'b1); waitDrain();

    // Back-pressure: hold DONE, poke in_valid in CONV and DONE, then release.
    forcedReady = 1'b0;
    applyStimulus(16'h0103, 8'h0F, 1'b0, 1'b0, 1'b1);
    in_valid = 1'b1;
    in_csd   = 16'h0001;
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("bpReachedDone", 32'(out_valid), 32'd1);
    for (int k = 0; k < 5; k++) begin
      checkOutput("bpValidHeld", 32'(out_valid), 32'd1);
      checkOutput("bpInReady", 32'(in_ready), 32'd0);
      checkOutput("bpBinHeld", 32'(out_bin), 32'h0F);
      @(posedge clk);
      #1;
    end
    expQ.push_back('{bin: 8'hFF, err: 1'b0, nc: 1'b0});
    in_csd      = 16'h0003;
    forcedReady = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("bpIdleInReady", 32'(in_ready), 32'd1);
    checkOutput("bpIdleOutValid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("bpAcceptedNext", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    waitDrain();

    // Reset in the middle of a conversion discards the word.
    applyStimulus(16'h5555, 8'hFF, 1'b0, 1'b1, 1'b1);
    waitDrain();
    applyStimulus(16'h0103, 8'h00, 1'b0, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    srst_n = 1'b0;
    @(posedge clk);
    #1;
    srst_n = 1'b1;
    checkOutput("abortOutValid", 32'(out_valid), 32'd0);
    checkOutput("abortInReady", 32'(in_ready), 32'd1);
    checkOutput("abortOutBin", 32'(out_bin), 32'd0);
    checkOutput("abortOutErr", 32'(out_err), 32'd0);
    checkOutput("abortOutNoncanon", 32'(out_noncanon), 32'd0);
    sawValid = 1'b0;
    for (int k = 0; k < W + 4; k++) begin
      @(posedge clk);
      #1;
      sawValid = sawValid | out_valid;
    end
    checkOutput("abortNoValid", 32'(sawValid), 32'd0);
    applyStimulus(16'h0103, 8'h0F, 1'b0, 1'b0, 1'b1);
    waitDrain();

    // Random canonical words with random consumer back-pressure.
    randomMode = 1'b1;
    for (int k = 0; k < 40; k++) begin
      v = W'($urandom);
      applyStimulus(bin2csd(v), v, 1'b0, 1'b0, 1'b1);
    end
    waitDrain();
    randomMode = 1'b0;

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
